// File: rtl/gpio_pkg.sv
// gpio_pkg: shared FSM state/phase types and default window, edge-threshold and loss-count constants
package gpio_pkg;
  typedef enum logic {ACQ, TRACK} state_t;
  typedef logic [1:0] phase_t;
  localparam int WIN_LOG2 = 6;
  localparam int MIN_EDGES = 4;
  localparam int LOSS_WINDOWS = 2;
endpackage

// File: rtl/gpio_edge_hist.sv
// gpio_edge_hist: per-phase saturating edge counters with lowest-index argmax; in clk/rst/en/clr/e[3:0], out peak/peak_cnt
module gpio_edge_hist
  import gpio_pkg::*;
#(
  parameter int WIN_LOG2 = gpio_pkg::WIN_LOG2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [3:0]        e,
  output phase_t            peak,
  output logic [WIN_LOG2:0] peak_cnt
);
  localparam int CW = WIN_LOG2 + 1;
  logic [CW-1:0] cnt [4];
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int k = 0; k < 4; k++) cnt[k] <= '0;
    else if (en) for (int k = 0; k < 4; k++) cnt[k] <= clr ? CW'(e[k]) : &cnt[k] ? cnt[k] : cnt[k] + CW'(e[k]);
  always_comb begin
    peak = '0;
    peak_cnt = cnt[0];
    for (int k = 1; k < 4; k++)
      if (cnt[k] > peak_cnt) begin
        peak = phase_t'(k);
        peak_cnt = cnt[k];
      end
  end
endmodule

// File: rtl/gpio_phase_picker.sv
// gpio_phase_picker: 4-phase oversampled data recovery; in clk/rst/en/samp[3:0], out dout/dout_valid/phase_sel/locked/phase_wrap
module gpio_phase_picker
  import gpio_pkg::*;
#(
  parameter int WIN_LOG2     = gpio_pkg::WIN_LOG2,
  parameter int MIN_EDGES    = gpio_pkg::MIN_EDGES,
  parameter int LOSS_WINDOWS = gpio_pkg::LOSS_WINDOWS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] samp,
  output logic       dout,
  output logic       dout_valid,
  output logic [1:0] phase_sel,
  output logic       locked,
  output logic       phase_wrap
);
  localparam int LW = $clog2(LOSS_WINDOWS + 1);
  logic [3:0] s1, e;
  logic p3, dec, valid, wrap;
  logic [WIN_LOG2-1:0] wcnt;
  logic [LW-1:0] loss, loss_n;
  logic [WIN_LOG2:0] peak_cnt;
  state_t state, state_n;
  phase_t peak, ps_n;
  assign e = {s1[3:1] ^ s1[2:0], s1[0] ^ p3};
  assign dec = en & (&wcnt);
  assign valid = peak_cnt >= (WIN_LOG2 + 1)'(MIN_EDGES);
  assign locked = state == TRACK;
  assign wrap = (phase_sel == 2'd3 && ps_n == 2'd0) || (phase_sel == 2'd0 && ps_n == 2'd3);
  gpio_edge_hist #(.WIN_LOG2(WIN_LOG2)) u_hist (
    .clk(clk), .rst(rst), .en(en), .clr(dec), .e(e), .peak(peak), .peak_cnt(peak_cnt)
  );
  always_comb begin
    state_n = state;
    loss_n = loss;
    ps_n = phase_sel;
    if (dec && valid) begin
      state_n = TRACK;
      loss_n = '0;
      ps_n = peak + 2'd2;
    end else if (dec && state == TRACK) begin
      loss_n = loss + 1'b1;
      if (loss_n >= LW'(LOSS_WINDOWS)) begin
        state_n = ACQ;
        loss_n = '0;
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ACQ;
    else if (en) state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= '0;
      p3 <= 1'b0;
      wcnt <= '0;
      loss <= '0;
      phase_sel <= '0;
      dout <= 1'b0;
      dout_valid <= 1'b0;
      phase_wrap <= 1'b0;
    end else begin
      dout_valid <= locked & en;
      phase_wrap <= wrap;
      if (en) begin
        s1 <= samp;
        p3 <= s1[3];
        wcnt <= wcnt + 1'b1;
        loss <= loss_n;
        phase_sel <= ps_n;
        dout <= s1[phase_sel];
      end
    end
endmodule

// File: tb/tb_gpio_phase_picker.sv
// tb_gpio_phase_picker: randomized directed scenarios checked against a behavioural window/histogram model
module tb_gpio_phase_picker;
  localparam int WIN = 64;
  localparam int MINE = 4;
  localparam int LOSS = 2;
  logic clk = 0, rst = 1, en = 0;
  logic [3:0] samp = '0;
  logic dout, dout_valid, locked, phase_wrap;
  logic [1:0] phase_sel;
  int total = 0, bad = 0, wraps = 0;
  bit lvl = 0;
  logic [3:0] m_s1;
  bit m_prev, m_lock, m_dout, m_dv, m_wrap;
  int hist[4];
  int m_en_cyc, m_loss, m_ps;

  gpio_phase_picker dut (
    .clk(clk), .rst(rst), .en(en), .samp(samp), .dout(dout), .dout_valid(dout_valid),
    .phase_sel(phase_sel), .locked(locked), .phase_wrap(phase_wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_prev = 0; m_lock = 0; m_dout = 0; m_dv = 0; m_wrap = 0;
    m_en_cyc = 0; m_loss = 0; m_ps = 0;
    for (int k = 0; k < 4; k++) hist[k] = 0;
  endtask

  // One clock edge of the reference: the sample stream is walked bit by bit in
  // time order, and a window closes every WIN enabled cycles counted from reset.
  task automatic model_step();
    int ed[4];
    int best, nps;
    bit last, nd, nw;
    if (rst) begin
      model_reset();
      return;
    end
    nd = m_lock && en;
    nw = 0;
    if (en) begin
      last = m_prev;
      for (int k = 0; k < 4; k++) begin
        ed[k] = (m_s1[k] != last) ? 1 : 0;
        last = m_s1[k];
      end
      m_dout = m_s1[m_ps];
      if (m_en_cyc % WIN == WIN - 1) begin
        best = 0;
        for (int k = 1; k < 4; k++) if (hist[k] > hist[best]) best = k;
        if (hist[best] >= MINE) begin
          nps = (best + 2) % 4;
          nw = (m_ps == 3 && nps == 0) || (m_ps == 0 && nps == 3);
          m_ps = nps; m_lock = 1; m_loss = 0;
        end else if (m_lock) begin
          m_loss++;
          if (m_loss >= LOSS) begin m_lock = 0; m_loss = 0; end
        end
        for (int k = 0; k < 4; k++) hist[k] = ed[k];
      end else begin
        for (int k = 0; k < 4; k++) hist[k] += ed[k];
      end
      m_prev = m_s1[3];
      m_s1 = samp;
      m_en_cyc++;
    end
    m_dv = nd;
    m_wrap = nw;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("dout", 32'(dout), 32'(m_dout));
    chk("dout_valid", 32'(dout_valid), 32'(m_dv));
    chk("phase_sel", 32'(phase_sel), 32'(m_ps));
    chk("locked", 32'(locked), 32'(m_lock));
    chk("phase_wrap", 32'(phase_wrap), 32'(m_wrap));
    wraps += 32'(phase_wrap);
  endtask

  // Edge at position p: bits below p keep the previous level, bits from p on carry the new one.
  task automatic drive(input int p, input bit rnd);
    bit nl;
    logic [3:0] low;
    nl = rnd ? 1'($urandom % 2) : !lvl;
    low = 4'((1 << p) - 1);
    samp = (nl == lvl) ? {4{lvl}} : (nl ? ~low : low);
    lvl = nl;
  endtask

  task automatic run(input int p, input int n, input bit rnd);
    repeat (n) begin
      drive(p, rnd);
      tick();
    end
  endtask

  initial begin
    int h[80];
    int k, ps0;
    model_reset();
    tick();
    tick();
    chk("rst_locked", 32'(locked), 0);
    chk("rst_phase_sel", 32'(phase_sel), 0);
    chk("rst_dout_valid", 32'(dout_valid), 0);
    rst = 0;
    en = 1;
    for (int n = 1; n <= 70; n++) begin
      drive(1, 0);
      h[n] = 32'(samp[3]);
      tick();
      if (n == 63) chk("pre_lock", 32'(locked), 0);
      if (n == 64) begin
        chk("lock_at_64", 32'(locked), 1);
        chk("lock_phase_3", 32'(phase_sel), 3);
      end
      if (n >= 66) chk("dout_lag2", 32'(dout), 32'(h[n - 1]));
    end
    wraps = 0;
    run(3, 128, 1);
    chk("move_to_3_ps", 32'(phase_sel), 1);
    chk("move_to_3_nowrap", wraps, 0);
    run(0, 128, 1);
    chk("pos0_ps", 32'(phase_sel), 2);
    wraps = 0;
    run(1, 128, 1);
    chk("pos1_ps", 32'(phase_sel), 3);
    run(2, 128, 1);
    chk("pos2_ps", 32'(phase_sel), 0);
    chk("single_wrap", wraps, 1);
    ps0 = 32'(phase_sel);
    k = 0;
    while (locked && k < 300) begin
      samp = 4'hf;
      tick();
      k++;
    end
    chk("loss_unlock", 32'(locked), 0);
    chk("loss_ps_hold", 32'(phase_sel), ps0);
    tick();
    chk("loss_dv_low", 32'(dout_valid), 0);
    run(2, 130, 1);
    chk("relock_en_test", 32'(locked), 1);
    run(2, 20, 1);
    en = 0;
    for (int i = 0; i < 10; i++) begin
      samp = 4'($urandom);
      tick();
      chk("en_low_dv", 32'(dout_valid), 0);
      chk("en_low_locked", 32'(locked), 1);
    end
    en = 1;
    run(0, 200, 1);
    chk("after_gap_ps", 32'(phase_sel), 2);
    run(2, 30, 1);
    #2;
    rst = 1;
    #1;
    chk("async_locked", 32'(locked), 0);
    chk("async_ps", 32'(phase_sel), 0);
    chk("async_dout", 32'(dout), 0);
    chk("async_dv", 32'(dout_valid), 0);
    chk("async_wrap", 32'(phase_wrap), 0);
    model_reset();
    tick();
    rst = 0;
    for (int n = 1; n <= 64; n++) begin
      drive(1, 0);
      tick();
      if (n == 63) chk("relock_pre", 32'(locked), 0);
      if (n == 64) begin
        chk("relock_at_64", 32'(locked), 1);
        chk("relock_ps", 32'(phase_sel), 3);
      end
    end
    repeat (8) begin
      k = int'($urandom % 4);
      repeat (100) begin
        en = ($urandom % 8) != 0;
        drive(k, 1);
        if ($urandom % 16 == 0) samp = 4'($urandom);
        tick();
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gpio_phase_picker.md
GPIO_PHASE_PICKER -- requirements
Module: gpio_phase_picker

Interface
REQ-001 Parameter WIN_LOG2, default 6, sets the edge-histogram window length to 2^WIN_LOG2 clk cycles.
REQ-002 Parameter MIN_EDGES, default 4, is the minimum peak edge count a window needs to be valid.
REQ-003 Parameter LOSS_WINDOWS, default 2, is the number of consecutive invalid windows that drops lock.
REQ-004 clk  input  1  the single clock, the phase-0 output of the GPIO PLL.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 en  input  1  when high, sampling and tracking run; when low, all state is frozen.
REQ-007 samp  input  4  oversampled line, retimed into clk; bit k is the phase-k sample (0/90/180/270 degrees); bit 0 is earliest.
REQ-008 dout  output  1  recovered data bit.
REQ-009 dout_valid  output  1  high when dout carries a recovered bit.
REQ-010 phase_sel  output  2  currently selected sample phase.
REQ-011 locked  output  1  high in state TRACK.
REQ-012 phase_wrap  output  1  one-cycle pulse when phase_sel changes between 3 and 0 in either direction.

Function
REQ-013 Stage 1 shall register samp into s1 and s1[3] into p3 on every cycle with en=1.
REQ-014 Edge vector from stage 1: e[0]=s1[0]^p3; e[k]=s1[k]^s1[k-1] for k=1..3.
REQ-015 Four edge counters, each WIN_LOG2+1 bits wide, shall add e[k] each enabled cycle and saturate at all-ones.
REQ-016 A window counter of WIN_LOG2 bits shall increment each enabled cycle and wrap; its terminal value is 2^WIN_LOG2-1.
REQ-017 On the terminal cycle, each edge counter shall load e[k] rather than accumulate.
REQ-018 The window decision on the terminal cycle shall use the registered counter values; the first window after reset therefore spans 2^WIN_LOG2-1 cycles.
REQ-019 Decision rule: peak = argmax of the counts, with ties going to the lowest index; candidate = (peak+2) mod 4.
REQ-020 A window is valid when the peak count is >= MIN_EDGES.
REQ-021 FSM has two states, ACQ (reset state) and TRACK.
REQ-022 ACQ -> TRACK on a valid window; phase_sel shall load the candidate on the same cycle.
REQ-023 In TRACK, a valid window shall load phase_sel with the candidate and clear the loss counter.
REQ-024 In TRACK, an invalid window shall increment the loss counter and hold phase_sel.
REQ-025 In TRACK, when the loss counter reaches LOSS_WINDOWS, the FSM shall return to ACQ and clear the loss counter, and phase_sel shall hold.
REQ-026 phase_wrap shall be asserted on the cycle after phase_sel changes from 3 to 0 or from 0 to 3; no other phase change asserts it.
REQ-027 dout shall be registered as s1[phase_sel], giving 2 clk edges of latency from samp to dout.
REQ-028 dout_valid shall be registered as locked & en, aligned with dout.
REQ-029 While en=0, all registers hold and dout_valid shall be 0 from the next cycle.
REQ-030 When a window decision and an en=0 cycle coincide, no decision shall be taken that cycle.

Reset
REQ-031 On rst: s1=0, p3=0, edge counters=0, window counter=0, loss counter=0, state=ACQ, phase_sel=0, dout=0, dout_valid=0, locked=0, phase_wrap=0.
REQ-032 Reset asserted mid-window shall discard the partial histogram; the first window after release is again 2^WIN_LOG2-1 cycles.

Structure
REQ-033 A shared package gpio_pkg shall hold the FSM state typedef (ACQ, TRACK), the phase-index typedef (2 bits) and the default constants WIN_LOG2, MIN_EDGES and LOSS_WINDOWS.
REQ-034 The edge histogram (edge counters plus argmax) shall be one sub-module, gpio_edge_hist; all other logic sits in gpio_phase_picker.

Verification
REQ-035 Scenario: with en=1, samp alternating 4'b1110 / 4'b0001 (edge at position 1) -> locked=1 on cycle 64 after reset release, phase_sel=3, dout alternating and equal to samp[3] delayed 2 cycles.
REQ-036 Scenario: edge position moved from 1 to 3 after lock -> at the next window end phase_sel goes 3 -> 1, and phase_wrap stays 0.
REQ-037 Scenario: edge position moved from 0 to 1 (phase_sel 2 -> 3), then from 1 to 2 (phase_sel 3 -> 0) -> exactly one phase_wrap pulse, on the cycle after the 3 -> 0 change.
REQ-038 Scenario: samp held at 4'b1111 after lock -> locked falls at the end of the 2nd invalid window, dout_valid=0 one cycle later, phase_sel unchanged.
REQ-039 Scenario: en=0 for 10 cycles mid-window -> counters frozen, dout_valid=0; the window terminal is delayed by exactly 10 cycles.
REQ-040 Scenario: rst pulsed asynchronously mid-window in TRACK -> all outputs 0 immediately; relock after 63 clean cycles.
